// File: rtl/gtmr_fault_monitor.sv
// Monitor for three GTMR replica buses: registered 2-of-3 vote, per-sample fault
// classification, saturating error count and sticky per-lane failure flags.
module gtmr_fault_monitor #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned PERSIST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] port_in_0,
   input  logic [WIDTH-1:0] port_in_1,
   input  logic [WIDTH-1:0] port_in_2,
   input  logic             clear,
   output logic [WIDTH-1:0] port_voted,
   output logic             err_valid,
   output logic [1:0]       err_lane,
   output logic [CNT_W-1:0] err_count,
   output logic [2:0]       lane_failed,
   output logic             uncorrectable
);

   localparam int unsigned STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(PERSIST);
   localparam logic [1:0] LANE_MULTI = 2'd3;

   logic [WIDTH-1:0] s0, s1, s2;
   logic [2:0][STREAK_W-1:0] streak;

   logic [WIDTH-1:0]         voted_c;
   logic [WIDTH-1:0]         min0_c, min1_c, min2_c;
   logic [2:0]               hit_c;
   logic                     err_c;
   logic                     multi_c;
   logic [1:0]               lane_c;
   logic [2:0][STREAK_W-1:0] streak_nxt_c;
   logic [2:0]               fail_set_c;

   // Stage 1: unconditional capture of the three replicas
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else begin
         s0 <= port_in_0;
         s1 <= port_in_1;
         s2 <= port_in_2;
      end
   end

   // Vote, per-bit minority lane, sample classification and streak update
   always_comb begin
      voted_c      = (s0 & s1) | (s1 & s2) | (s0 & s2);
      min0_c       = (s0 ^ s1) & ~(s1 ^ s2);
      min1_c       = (s1 ^ s0) & ~(s0 ^ s2);
      min2_c       = (s2 ^ s0) & ~(s0 ^ s1);
      hit_c        = {|min2_c, |min1_c, |min0_c};
      err_c        = |hit_c;
      multi_c      = !$onehot0(hit_c);
      lane_c       = LANE_MULTI;
      streak_nxt_c = '0;
      fail_set_c   = '0;
      case (hit_c)
         3'b001:  lane_c = 2'd0;
         3'b010:  lane_c = 2'd1;
         3'b100:  lane_c = 2'd2;
         default: lane_c = LANE_MULTI;
      endcase
      for (int i = 0; i < 3; i++) begin
         if (hit_c[i] && !multi_c) begin
            streak_nxt_c[i] = (streak[i] >= STREAK_MAX) ? STREAK_MAX
                                                        : streak[i] + STREAK_W'(1);
            fail_set_c[i]   = (streak_nxt_c[i] == STREAK_MAX);
         end
      end
   end

   // Stage 2: registered results; clear wins over same-cycle sticky updates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_voted    <= '0;
         err_valid     <= 1'b0;
         err_lane      <= 2'd0;
         err_count     <= '0;
         lane_failed   <= 3'b000;
         uncorrectable <= 1'b0;
         streak        <= '0;
      end else begin
         port_voted <= voted_c;
         err_valid  <= err_c;
         if (err_c) begin
            err_lane <= lane_c;
         end
         if (clear) begin
            err_count     <= '0;
            lane_failed   <= 3'b000;
            uncorrectable <= 1'b0;
            streak        <= '0;
         end else begin
            streak      <= streak_nxt_c;
            lane_failed <= lane_failed | fail_set_c;
            if (err_c && multi_c) begin
               uncorrectable <= 1'b1;
            end
            if (err_c && (err_count != {CNT_W{1'b1}})) begin
               err_count <= err_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_gtmr_fault_monitor.sv
// Directed bench for gtmr_fault_monitor: a WIDTH=1/CNT_W=8 instance and a
// WIDTH=2/CNT_W=2 instance sharing clock and reset.
module tb_gtmr_fault_monitor;

   logic clk = 1'b0;
   logic rst_n;

   logic       a0, a1, a2, clear_a;
   logic       voted_a, err_valid_a, unc_a;
   logic [1:0] err_lane_a;
   logic [7:0] err_count_a;
   logic [2:0] lane_failed_a;

   logic [1:0] b0, b1, b2;
   logic       clear_b;
   logic [1:0] voted_b;
   logic       err_valid_b, unc_b;
   logic [1:0] err_lane_b;
   logic [1:0] err_count_b;
   logic [2:0] lane_failed_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gtmr_fault_monitor #(.WIDTH(1), .CNT_W(8), .PERSIST(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .port_in_0(a0), .port_in_1(a1), .port_in_2(a2), .clear(clear_a),
      .port_voted(voted_a), .err_valid(err_valid_a), .err_lane(err_lane_a),
      .err_count(err_count_a), .lane_failed(lane_failed_a), .uncorrectable(unc_a)
   );

   gtmr_fault_monitor #(.WIDTH(2), .CNT_W(2), .PERSIST(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .port_in_0(b0), .port_in_1(b1), .port_in_2(b2), .clear(clear_b),
      .port_voted(voted_b), .err_valid(err_valid_b), .err_lane(err_lane_b),
      .err_count(err_count_b), .lane_failed(lane_failed_b), .uncorrectable(unc_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_voted"}, 32'(voted_a), 0);
      check({tag, "_valid"}, 32'(err_valid_a), 0);
      check({tag, "_lane"},  32'(err_lane_a), 0);
      check({tag, "_count"}, 32'(err_count_a), 0);
      check({tag, "_failed"}, 32'(lane_failed_a), 0);
      check({tag, "_unc"},   32'(unc_a), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      clear_a = 1'b0; clear_b = 1'b0;
      a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
      b0 = 2'b00; b1 = 2'b00; b2 = 2'b00;
      repeat (2) step();
      check_a_zero("rst");
      check("rst_b_voted", 32'(voted_b), 0);
      rst_n = 1'b1;

      // All lanes agree at 1
      a0 = 1'b1; a1 = 1'b1; a2 = 1'b1;
      step();
      check("agree_latency", 32'(voted_a), 0);
      for (int i = 0; i < 9; i++) begin
         step();
         check("agree_voted", 32'(voted_a), 1);
         check("agree_valid", 32'(err_valid_a), 0);
      end
      check("agree_count", 32'(err_count_a), 0);

      // Lane 1 wrong for three samples
      a1 = 1'b0;
      step();
      check("l1_pre_valid", 32'(err_valid_a), 0);
      repeat (2) begin
         step();
         check("l1_valid", 32'(err_valid_a), 1);
         check("l1_lane", 32'(err_lane_a), 1);
         check("l1_voted", 32'(voted_a), 1);
      end
      a1 = 1'b1;
      step();
      check("l1_last_valid", 32'(err_valid_a), 1);
      check("l1_count", 32'(err_count_a), 3);
      step();
      check("l1_end_valid", 32'(err_valid_a), 0);
      check("l1_lane_hold", 32'(err_lane_a), 1);
      check("l1_end_count", 32'(err_count_a), 3);
      check("l1_failed", 32'(lane_failed_a), 0);

      // Lane 2 wrong for PERSIST samples, then recovers
      clear_a = 1'b1;
      step();
      clear_a = 1'b0;
      check("clr_count", 32'(err_count_a), 0);
      a2 = 1'b0;
      step();
      check("l2_pre_valid", 32'(err_valid_a), 0);
      repeat (3) begin
         step();
         check("l2_valid", 32'(err_valid_a), 1);
         check("l2_lane", 32'(err_lane_a), 2);
      end
      check("l2_not_yet", 32'(lane_failed_a), 0);
      a2 = 1'b1;
      step();
      check("l2_failed", 32'(lane_failed_a), 3'b100);
      check("l2_count", 32'(err_count_a), 4);
      step();
      check("l2_sticky", 32'(lane_failed_a), 3'b100);
      check("l2_end_valid", 32'(err_valid_a), 0);
      check("l2_end_count", 32'(err_count_a), 4);

      // Reset in the middle of a lane-1 streak
      a1 = 1'b0;
      repeat (4) step();
      check("mid_count", 32'(err_count_a), 7);
      rst_n = 1'b0;
      #1;
      check_a_zero("async_rst");
      step();
      rst_n = 1'b1;
      repeat (3) step();
      a1 = 1'b1;
      step();
      check("post_rst_valid", 32'(err_valid_a), 1);
      check("post_rst_count", 32'(err_count_a), 3);
      check("post_rst_failed", 32'(lane_failed_a), 0);
      step();
      check("post_rst_failed2", 32'(lane_failed_a), 0);
      check("post_rst_valid2", 32'(err_valid_a), 0);

      // WIDTH=2: lane-0 streak broken by a multi-lane sample
      b0 = 2'b01;
      repeat (3) step();
      b0 = 2'b01; b1 = 2'b00; b2 = 2'b10;
      step();
      check("b_l0_lane", 32'(err_lane_b), 0);
      check("b_l0_count_sat", 32'(err_count_b), 3);
      b0 = 2'b01; b1 = 2'b00; b2 = 2'b00;
      step();
      check("multi_valid", 32'(err_valid_b), 1);
      check("multi_lane", 32'(err_lane_b), 3);
      check("multi_voted", 32'(voted_b), 2'b00);
      check("multi_unc", 32'(unc_b), 1);
      b0 = 2'b00;
      step();
      check("b_after_multi_failed", 32'(lane_failed_b), 0);
      check("b_after_multi_lane", 32'(err_lane_b), 0);
      step();
      check("b_agree_valid", 32'(err_valid_b), 0);
      check("b_unc_sticky", 32'(unc_b), 1);

      // Per-bit majority with lane 1 minority on bit 0
      b0 = 2'b11; b1 = 2'b10; b2 = 2'b11;
      step();
      b0 = 2'b00; b1 = 2'b00; b2 = 2'b00;
      step();
      check("maj_voted", 32'(voted_b), 2'b11);
      check("maj_lane", 32'(err_lane_b), 1);

      // Saturation, then clear coinciding with an error
      clear_b = 1'b1;
      step();
      clear_b = 1'b0;
      check("b_clr_count", 32'(err_count_b), 0);
      check("b_clr_unc", 32'(unc_b), 0);
      b0 = 2'b01;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         check("sat_valid", 32'(err_valid_b), 1);
      end
      check("sat_count", 32'(err_count_b), 3);
      check("sat_failed", 32'(lane_failed_b), 3'b001);
      clear_b = 1'b1;
      step();
      clear_b = 1'b0;
      check("clr_err_valid", 32'(err_valid_b), 1);
      check("clr_err_count", 32'(err_count_b), 0);
      check("clr_err_failed", 32'(lane_failed_b), 0);
      step();
      check("after_clr_count", 32'(err_count_b), 1);
      check("after_clr_failed", 32'(lane_failed_b), 0);
      b0 = 2'b00;
      repeat (2) step();
      check("b_end_valid", 32'(err_valid_b), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
